// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter: bus width, default
// memory depth and the owner encoding used by the response register.
package rom_arbiter_pkg;

   localparam int RegBus          = 32;
   localparam int DEFAULT_MEM_NUM = 4096;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Pick logic for the two-requester program-memory arbiter.
// M1 wins a conflict unless M0 is favoured, either because it is starving
// or because M1 was the last master granted on a conflict.
// Output is one-hot: gnt[0] = M0, gnt[1] = M1; all-zero when nobody asks.
module rom_arb_pick
   import rom_arbiter_pkg::*;
(
   input  logic       m0_req,
   input  logic       m1_req,
   input  owner_e     last_owner,
   input  logic       starve,
   output logic [1:0] gnt
);

   logic m0_favoured;

   // M0 takes a conflict when starving or when M1 had the previous conflict
   assign m0_favoured = starve || (last_owner == OWN_M1);

   // Single-winner selection
   always_comb begin
      gnt = 2'b00;
      if (m0_req && m1_req) begin
         if (m0_favoured) begin
            gnt = 2'b01;
         end else begin
            gnt = 2'b10;
         end
      end else if (m0_req) begin
         gnt = 2'b01;
      end else if (m1_req) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter/sequencer for the program memory (registered read,
// one-cycle latency). M0 = instruction fetch (read-only), M1 = load/store.
// Byte addresses become word indices; misaligned or out-of-range accesses
// are granted but answered with err instead of touching the memory.
// Build option: define ROM_ARB_RR_EN for round-robin conflict resolution;
// otherwise M1 has fixed priority with M0 promoted after STARVE_MAX denials.
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int AW         = RegBus,
   parameter int DW         = RegBus,
   parameter int MEM_NUM    = DEFAULT_MEM_NUM,
   parameter int STARVE_MAX = 8
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_err,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,

   output logic          mem_ren,
   output logic          mem_wen,
   output logic [AW-1:0] mem_raddr,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_NUM);

   logic [1:0]    pick_gnt;
   owner_e        pick_last;
   logic          pick_starve;

   logic          any_gnt;
   logic          gnt_we;
   logic          gnt_err;
   logic [AW-1:0] gnt_addr;
   logic [AW-1:0] gnt_word;

   logic          rsp_valid;
   owner_e        rsp_owner;
   logic          rsp_err;
   logic          rsp_rd;

   rom_arb_pick u_pick (
      .m0_req     (m0_req),
      .m1_req     (m1_req),
      .last_owner (pick_last),
      .starve     (pick_starve),
      .gnt        (pick_gnt)
   );

   // No grant can leave the arbiter while reset is held
   assign m0_gnt  = pick_gnt[0] && !rst;
   assign m1_gnt  = pick_gnt[1] && !rst;
   assign any_gnt = m0_gnt || m1_gnt;

`ifdef ROM_ARB_RR_EN
   owner_e rr_last;

   // Remember who won the last conflict; non-conflict grants leave it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_last <= OWN_M0;
      end else if (m0_req && m1_req && any_gnt) begin
         rr_last <= m1_gnt ? OWN_M1 : OWN_M0;
      end
   end

   assign pick_last   = rr_last;
   assign pick_starve = 1'b0;
`else
   localparam int             SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;

   // Count consecutive cycles M0 is left waiting, saturating at the top
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (m0_req && !m0_gnt) begin
         if (starve_cnt != STARVE_TOP) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   assign pick_last   = OWN_M0;
   assign pick_starve = (starve_cnt == STARVE_TOP);
`endif

   // Granted transaction attributes and legality
   always_comb begin
      gnt_addr = m1_gnt ? m1_addr : m0_addr;
      gnt_we   = m1_gnt && m1_we;
      gnt_word = {2'b00, gnt_addr[AW-1:2]};
      gnt_err  = (gnt_addr[1:0] != 2'b00) || (gnt_word >= MEM_LIMIT);
   end

   // Memory port drive; everything idles at zero without a legal grant
   always_comb begin
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_raddr = '0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (any_gnt && !gnt_err) begin
         if (gnt_we) begin
            mem_wen   = 1'b1;
            mem_waddr = gnt_word;
            mem_wdata = m1_wdata;
         end else begin
            mem_ren   = 1'b1;
            mem_raddr = gnt_word;
         end
      end
   end

   // Response register: one entry per grant, returned the following cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_owner <= OWN_M0;
         rsp_err   <= 1'b0;
         rsp_rd    <= 1'b0;
      end else begin
         rsp_valid <= any_gnt;
         rsp_owner <= m1_gnt ? OWN_M1 : OWN_M0;
         rsp_err   <= any_gnt && gnt_err;
         rsp_rd    <= any_gnt && !gnt_err && !gnt_we;
      end
   end

   // Route the response to its owner; data only for clean reads
   always_comb begin
      m0_rvalid = rsp_valid && (rsp_owner == OWN_M0) && !rst;
      m1_rvalid = rsp_valid && (rsp_owner == OWN_M1) && !rst;
      m0_err    = m0_rvalid && rsp_err;
      m1_err    = m1_rvalid && rsp_err;
      m0_rdata  = (m0_rvalid && rsp_rd) ? mem_rdata : '0;
      m1_rdata  = (m1_rvalid && rsp_rd) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered-read memory model.
module tb_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req;
   logic [31:0] m0_addr;
   logic        m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_rdata;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:4095];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   rom_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m0_err    (m0_err),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .m1_err    (m1_err),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_raddr (mem_raddr),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Memory model: preloaded words on reset, one-cycle registered read
   always @(posedge clk) begin
      if (rst) begin
         mem[4]    <= 32'hDEAD_BEEF;
         mem[4095] <= 32'hCAFE_F00D;
         mem_rdata <= 32'h0;
      end else begin
         if (mem_wen) mem[mem_waddr[11:0]] <= mem_wdata;
         if (mem_ren) mem_rdata <= mem[mem_raddr[11:0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_req = 1'b0; m0_addr = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h10;
      m1_req = 1'b1; m1_addr = 32'h20;
      tick(); tick();
      total++; if (m0_gnt !== 1'b0) $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); else passed++;
      total++; if (m1_gnt !== 1'b0) $display("FAIL rst_m1_gnt: got %b want 0", m1_gnt); else passed++;
      total++; if (mem_ren !== 1'b0) $display("FAIL rst_mem_ren: got %b want 0", mem_ren); else passed++;
      total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); else passed++;
      total++; if (m0_err !== 1'b0 || m1_err !== 1'b0) $display("FAIL rst_err: got %b%b want 00", m0_err, m1_err); else passed++;
      total++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) $display("FAIL rst_rdata: got %h %h want 0", m0_rdata, m1_rdata); else passed++;
      idle();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read();
      m0_req = 1'b1; m0_addr = 32'h0000_0010;
      #1;
      total++; if (m0_gnt !== 1'b1) $display("FAIL rd_gnt: got %b want 1", m0_gnt); else passed++;
      total++; if (mem_ren !== 1'b1 || mem_raddr !== 32'd4) $display("FAIL rd_mem: got ren=%b raddr=%0d want ren=1 raddr=4", mem_ren, mem_raddr); else passed++;
      tick();
      idle();
      #1;
      total++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) $display("FAIL rd_rvalid: got %b%b want 10", m0_rvalid, m1_rvalid); else passed++;
      total++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", m0_rdata); else passed++;
      total++; if (m0_err !== 1'b0) $display("FAIL rd_err: got %b want 0", m0_err); else passed++;
      tick();
      total++; if (m0_rvalid !== 1'b0) $display("FAIL rd_single_pulse: got %b want 0", m0_rvalid); else passed++;
   endtask

   task automatic test_write_read();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
      #1;
      total++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) $display("FAIL wr_gnt: got m1=%b m0=%b want 1 0", m1_gnt, m0_gnt); else passed++;
      total++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_waddr !== 32'd8) $display("FAIL wr_mem: got wen=%b ren=%b waddr=%0d want 1 0 8", mem_wen, mem_ren, mem_waddr); else passed++;
      total++; if (mem_wdata !== 32'h1234_5678) $display("FAIL wr_wdata: got %h want 12345678", mem_wdata); else passed++;
      tick();
      idle();
      m0_req = 1'b1; m0_addr = 32'h20;
      #1;
      total++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) $display("FAIL wr_rsp: got m1=%b m0=%b want 1 0", m1_rvalid, m0_rvalid); else passed++;
      total++; if (m1_rdata !== 32'h0 || m1_err !== 1'b0) $display("FAIL wr_rsp_data: got %h err=%b want 0 0", m1_rdata, m1_err); else passed++;
      total++; if (m0_gnt !== 1'b1 || mem_ren !== 1'b1 || mem_raddr !== 32'd8) $display("FAIL wr_b2b_rd: got gnt=%b ren=%b raddr=%0d want 1 1 8", m0_gnt, mem_ren, mem_raddr); else passed++;
      tick();
      idle();
      #1;
      total++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) $display("FAIL wr_rd_rsp: got m0=%b m1=%b want 1 0", m0_rvalid, m1_rvalid); else passed++;
      total++; if (m0_rdata !== 32'h1234_5678) $display("FAIL wr_rd_data: got %h want 12345678", m0_rdata); else passed++;
      tick();
      total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) $display("FAIL wr_rd_quiet: got %b%b want 00", m0_rvalid, m1_rvalid); else passed++;
   endtask

   task automatic test_errors();
      m1_req = 1'b1; m1_addr = 32'h6;
      #1;
      total++; if (m1_gnt !== 1'b1) $display("FAIL err_mis_gnt: got %b want 1", m1_gnt); else passed++;
      total++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) $display("FAIL err_mis_mem: got ren=%b wen=%b want 0 0", mem_ren, mem_wen); else passed++;
      tick();
      m1_addr = 32'h4000;
      #1;
      total++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) $display("FAIL err_mis_rsp: got v=%b e=%b d=%h want 1 1 0", m1_rvalid, m1_err, m1_rdata); else passed++;
      total++; if (m1_gnt !== 1'b1 || mem_ren !== 1'b0 || mem_wen !== 1'b0) $display("FAIL err_oor_gnt: got gnt=%b ren=%b wen=%b want 1 0 0", m1_gnt, mem_ren, mem_wen); else passed++;
      tick();
      m1_req = 1'b0;
      m0_req = 1'b1; m0_addr = 32'h3FFC;
      #1;
      total++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) $display("FAIL err_oor_rsp: got v=%b e=%b d=%h want 1 1 0", m1_rvalid, m1_err, m1_rdata); else passed++;
      total++; if (m0_gnt !== 1'b1 || mem_ren !== 1'b1 || mem_raddr !== 32'd4095) $display("FAIL err_last_word: got gnt=%b ren=%b raddr=%0d want 1 1 4095", m0_gnt, mem_ren, mem_raddr); else passed++;
      tick();
      m0_addr = 32'h2;
      #1;
      total++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hCAFE_F00D) $display("FAIL err_last_rsp: got v=%b e=%b d=%h want 1 0 cafef00d", m0_rvalid, m0_err, m0_rdata); else passed++;
      total++; if (m0_gnt !== 1'b1 || mem_ren !== 1'b0) $display("FAIL err_m0_mis: got gnt=%b ren=%b want 1 0", m0_gnt, mem_ren); else passed++;
      tick();
      idle();
      #1;
      total++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) $display("FAIL err_m0_rsp: got v=%b e=%b d=%h want 1 1 0", m0_rvalid, m0_err, m0_rdata); else passed++;
      tick();
      total++; if (m0_err !== 1'b0 || m1_err !== 1'b0) $display("FAIL err_quiet: got %b%b want 00", m0_err, m1_err); else passed++;
   endtask

   task automatic test_conflict();
      logic exp_m0;
      m0_req = 1'b1; m0_addr = 32'h10;
      m1_req = 1'b1; m1_addr = 32'h20; m1_we = 1'b0;
      for (int i = 0; i < 18; i++) begin
         #1;
`ifdef ROM_ARB_RR_EN
         exp_m0 = (i % 2) == 1;
`else
         exp_m0 = (i % 9) == 8;
`endif
         total++; if (m0_gnt !== exp_m0 || m1_gnt !== !exp_m0) $display("FAIL conflict_cyc%0d: got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, exp_m0, !exp_m0); else passed++;
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      m0_req = 1'b1; m0_addr = 32'h10;
      #1;
      total++; if (m0_gnt !== 1'b1) $display("FAIL mid_gnt: got %b want 1", m0_gnt); else passed++;
      @(posedge clk);
      rst = 1'b1;
      idle();
      #1;
      total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) $display("FAIL mid_discard: got %b%b want 00", m0_rvalid, m1_rvalid); else passed++;
      tick();
      rst = 1'b0;
      total++; if (m0_rvalid !== 1'b0) $display("FAIL mid_release: got %b want 0", m0_rvalid); else passed++;
      tick();
      total++; if (m0_rvalid !== 1'b0) $display("FAIL mid_after: got %b want 0", m0_rvalid); else passed++;
      m0_req = 1'b1; m0_addr = 32'h3FFC;
      #1;
      total++; if (m0_gnt !== 1'b1 || mem_raddr !== 32'd4095) $display("FAIL mid_fresh_gnt: got gnt=%b raddr=%0d want 1 4095", m0_gnt, mem_raddr); else passed++;
      tick();
      idle();
      #1;
      total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hCAFE_F00D) $display("FAIL mid_fresh_rsp: got v=%b d=%h want 1 cafef00d", m0_rvalid, m0_rdata); else passed++;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_read();
      test_write_read();
      test_errors();
      test_conflict();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter and sequencer for the single-port-per-direction program memory (`rom`, registered read, 1-cycle latency). Shares the memory between the instruction-fetch unit (M0, read-only) and the load/store/loader path (M1, read/write). Converts byte addresses to word indices, checks alignment and range, and returns each response to its owner one cycle after grant.

## Interface
- `AW`, 32: address width (byte address).
- `DW`, 32: data width.
- `MEM_NUM`, 4096: memory depth in words.
- `STARVE_MAX`, 8: consecutive denied M0 cycles before M0 is promoted (fixed-priority mode).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `m0_req`  in  1  M0 read request; held with `m0_addr` until `m0_gnt`.
- `m0_addr`  in  AW  M0 byte address.
- `m0_gnt`  out  1  M0 accepted this cycle (combinational).
- `m0_rvalid`  out  1  M0 response valid.
- `m0_rdata`  out  DW  M0 read data.
- `m0_err`  out  1  M0 response is an error; qualified by `m0_rvalid`.
- `m1_req`, `m1_we`  in  1  M1 request, write select.
- `m1_addr`  in  AW  M1 byte address.
- `m1_wdata`  in  DW  M1 write data.
- `m1_gnt`, `m1_rvalid`, `m1_err`  out  1  as for M0.
- `m1_rdata`  out  DW  M1 read data.
- `mem_ren`, `mem_wen`  out  1  memory read and write enables.
- `mem_raddr`, `mem_waddr`  out  AW  word index (byte address >> 2, zero-extended).
- `mem_wdata`  out  DW  write data.
- `mem_rdata`  in  DW  registered memory read data.

## Operation
- At most one grant per cycle. A grant is issued iff the chosen requester has `req`=1 and `rst`=0.
- Conflict (both request), fixed-priority mode: M1 wins unless `starve_cnt` == STARVE_MAX, then M0 wins.
- `starve_cnt` (width clog2(STARVE_MAX+1)): increments, saturating, while `m0_req` && !`m0_gnt`; clears on `m0_gnt` or `m0_req`=0.
- Error check at grant: `addr[1:0]` != 0 or `addr[AW-1:2]` >= MEM_NUM. An errored grant still asserts `gnt`, drives no memory enable, and produces `err`=1, `rdata`=0.
- Legal read grant: `mem_ren`=1, `mem_raddr`=addr>>2. Legal write grant: `mem_wen`=1, `mem_waddr`=addr>>2, `mem_wdata`=`m1_wdata`.
- Response register {valid, owner, err} loads on every grant. Every grant (read, write, error) yields exactly one `rvalid` pulse to its owner the next cycle; for writes `rdata`=0.
- `mN_rdata` = `mem_rdata` when that master's `rvalid` && !err, else 0.
- Memory outputs are 0 when no legal grant.

## Timing
- Cycle T: `req` && `gnt`, memory enable (combinational). T+1: `rvalid`, `rdata`, `err`.
- Throughput one transaction per cycle; back-to-back grants to either or alternating masters allowed.
- A new request may be granted in T+1, concurrently with the T response.
- Reset values: `rvalid`=0, `err`=0, `rdata`=0, `starve_cnt`=0, round-robin pointer=M0. While `rst`=1, grants and memory enables are 0.
- Reset asserted mid-transaction: the outstanding response is discarded. No `rvalid` is returned for a grant in the cycle before reset.

## Configuration
- `ROM_ARB_RR_EN` defined: round-robin arbitration. On conflict, the master not granted last wins. The pointer updates only on a conflict grant. `starve_cnt` is not built.
- `ROM_ARB_RR_EN` undefined: fixed M1 priority with the starvation promotion above.

## Structure
- The owner encoding (M0=0, M1=1) and the default MEM_NUM belong in the shared defines file alongside `RegBus`.
- Sub-module `rom_arb_pick` contains the pick logic: inputs are both requests, the priority/pointer state, and the starve flag; the output is a one-hot grant. The top level holds the counters, error check, and response register.

## Test plan
- M0 reads 0x0000_0010 with memory word 4 = 0xDEAD_BEEF -> `mem_raddr`=4 at T; `m0_rvalid`=1, `m0_rdata`=0xDEAD_BEEF at T+1.
- M1 writes 0x1234_5678 to 0x20, then M0 reads 0x20 -> `mem_wen`, `mem_waddr`=8; the M0 response is 0x1234_5678; each master gets exactly one `rvalid`.
- M1 reads 0x6 (misaligned) and 0x4000 (word 4096, out of range) -> `gnt`=1, no memory enable, `m1_err`=1 with `rdata`=0 one cycle later.
- Both request continuously, fixed mode -> M1 granted 8 cycles, M0 granted on cycle 9, `starve_cnt` returns to 0. Round-robin build -> grants alternate M1, M0, M1, ...
- Read granted at T, `rst` pulsed during T+1 -> no `rvalid` appears; after release, a fresh read completes normally.
